// File: rtl/apb_slave_regfile.sv
// APB completer register bank: read-only ID word at index 0, DEPTH-1 R/W words, sticky
// protocol-error flag and completed-transfer counters. Define APB_SLV_WAIT_EN for Pready/wait states.
module apb_slave_regfile #(
    parameter int unsigned PSEL_IDX    = 0,
    parameter int unsigned DEPTH       = 16,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0001,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
`ifdef APB_SLV_WAIT_EN
    output logic        Pready,
`endif
    output logic        proto_err,
    output logic [15:0] wr_count,
    output logic [15:0] rd_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (PSEL_IDX > 2) begin : g_chk_psel
        $error("apb_slave_regfile: PSEL_IDX must be 0..2");
    end
    if (DEPTH < 2 || DEPTH > 256 || (DEPTH & (DEPTH - 1)) != 0) begin : g_chk_depth
        $error("apb_slave_regfile: DEPTH must be a power of 2 in 2..256");
    end

    // The state names the bus phase already seen: SETUP means a setup cycle was sampled
    // and the first access cycle is due now; ACCESS means an access is stretched by waits.
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
    state_t state, state_nxt;

    logic          sel;
    logic          hold_ok;
    logic          access_ok;
    logic          ready_now;
    logic          complete;
    logic          do_setup;
    logic          set_err;
    logic          unused_ok;

    logic [31:0]   addr_q;
    logic          write_q;
    logic [31:0]   wdata_q;
    logic [AW-1:0] idx;
    logic [AW-1:0] idx_q;
    logic [31:0]   bank [DEPTH];

    assign sel       = Pselx[PSEL_IDX];
    assign idx       = Paddr[AW+1:2];
    assign idx_q     = addr_q[AW+1:2];
    assign hold_ok   = (Paddr == addr_q) && (Pwrite == write_q) && (Pwdata == wdata_q);
    assign unused_ok = ^{Pselx, 32'(WAIT_CYCLES)};

`ifdef APB_SLV_WAIT_EN
    localparam int unsigned CW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;
    logic          cnt_dec;

    assign ready_now = (wait_cnt == '0);
    assign cnt_dec   = access_ok && !ready_now;
    assign Pready    = complete && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (do_setup) begin
            wait_cnt <= CW'(WAIT_CYCLES);
        end else if (cnt_dec) begin
            wait_cnt <= wait_cnt - CW'(1);
        end
    end
`else
    assign ready_now = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                state_nxt = do_setup ? SETUP : IDLE;
            end
            SETUP, ACCESS: begin
                if (access_ok) begin
                    state_nxt = complete ? IDLE : ACCESS;
                end else begin
                    state_nxt = do_setup ? SETUP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A held-stable access cycle either completes or waits; anything else is a violation.
    always_comb begin
        access_ok = (state != IDLE) && sel && Penable && hold_ok;
        complete  = access_ok && ready_now;
        do_setup  = sel && !Penable && (state != ACCESS);
        set_err   = (state == IDLE) ? (sel && Penable) : !access_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Prdata    <= '0;
            proto_err <= 1'b0;
            wr_count  <= '0;
            rd_count  <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
        end else begin
            if (set_err) begin
                proto_err <= 1'b1;
            end
            if (do_setup) begin
                addr_q  <= Paddr;
                write_q <= Pwrite;
                wdata_q <= Pwdata;
                if (!Pwrite) begin
                    Prdata <= (idx == '0) ? ID_VALUE : bank[idx];
                end
            end
            if (complete) begin
                if (write_q) begin
                    if (idx_q != '0) begin
                        bank[idx_q] <= wdata_q;
                    end
                    wr_count <= wr_count + 16'd1;
                end else begin
                    rd_count <= rd_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: driver pushes expectations from an array model,
// monitor pops and compares on every completing access cycle.
module tb_apb_slave_regfile;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WAITC = 2;
    localparam logic [31:0] IDV   = 32'hA5B0_0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  Pselx;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        proto_err;
    logic [15:0] wr_count;
    logic [15:0] rd_count;
    logic        ready;

    always #5 clk = ~clk;

`ifdef APB_SLV_WAIT_EN
    logic Pready;
    assign ready = Pready;
`else
    assign ready = 1'b1;
`endif

    apb_slave_regfile #(
        .PSEL_IDX(1),
        .DEPTH(DEPTH),
        .ID_VALUE(IDV),
        .WAIT_CYCLES(WAITC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .Pselx(Pselx),
        .Penable(Penable),
        .Pwrite(Pwrite),
        .Paddr(Paddr),
        .Pwdata(Pwdata),
        .Prdata(Prdata),
`ifdef APB_SLV_WAIT_EN
        .Pready(Pready),
`endif
        .proto_err(proto_err),
        .wr_count(wr_count),
        .rd_count(rd_count)
    );

    typedef struct {
        bit          w;
        logic [31:0] rdata;
        logic [15:0] wrc;
        logic [15:0] rdc;
        bit          err;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] model [DEPTH];
    logic [15:0] m_wr;
    logic [15:0] m_rd;
    bit          m_err;
    bit          bad_phase;
    int          checks = 0;
    int          errors = 0;
    int unsigned acc_cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int unsigned widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    function automatic logic [31:0] mread(input int unsigned i);
        return (i == 0) ? IDV : model[i];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
        m_wr  = '0;
        m_rd  = '0;
        m_err = 1'b0;
    endtask

    // All bus tasks start and end at posedge+1.
    task automatic do_reset();
        rst     = 1'b1;
        Pselx   = '0;
        Penable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            Pselx   = 3'($urandom) & 3'b101;
            Penable = 1'($urandom);
            Paddr   = $urandom;
            @(posedge clk);
            #1;
        end
        Pselx   = '0;
        Penable = 1'b0;
    endtask

    task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t        e;
        int unsigned n;
        e.w     = w;
        e.rdata = w ? 32'h0 : mread(widx(a));
        e.wrc   = m_wr;
        e.rdc   = m_rd;
        e.err   = m_err;
        q.push_back(e);
        if (w) begin
            if (widx(a) != 0) model[widx(a)] = d;
            m_wr = m_wr + 16'd1;
        end else begin
            m_rd = m_rd + 16'd1;
        end
        Pselx   = 3'b010;
        Penable = 1'b0;
        Pwrite  = w;
        Paddr   = a;
        Pwdata  = d;
        @(posedge clk);
        #1;
        Penable = 1'b1;
        n = 0;
        @(negedge clk);
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout actual=0 required=1 addr=%h", a);
        end
        @(posedge clk);
        #1;
        Pselx   = '0;
        Penable = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && !bad_phase && Pselx[1] && Penable) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_access actual=access required=none addr=%h", Paddr);
            end else begin
                mon_e = q[0];
                if (!mon_e.w) chk("prdata", Prdata, mon_e.rdata);
`ifdef APB_SLV_WAIT_EN
                chk("pready", 32'(Pready), 32'(acc_cyc == WAITC));
`endif
                if (ready) begin
                    chk("wr_count", 32'(wr_count), 32'(mon_e.wrc));
                    chk("rd_count", 32'(rd_count), 32'(mon_e.rdc));
                    chk("proto_err", 32'(proto_err), 32'(mon_e.err));
                    void'(q.pop_front());
                    acc_cyc = 0;
                end else begin
                    acc_cyc++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bad_phase = 1'b0;
        Pwrite    = 1'b0;
        Paddr     = '0;
        Pwdata    = '0;
        #1;
        do_reset();

        // Reset in the middle of a write wipes the bank and all status.
        xfer(1'b1, 32'h8000_000C, 32'hDEAD_BEEF);
        bad_phase = 1'b1;
        Pselx   = 3'b010;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_000C;
        Pwdata  = 32'h1111_1111;
        @(posedge clk);
        #1;
        Penable = 1'b1;
        rst     = 1'b1;
        @(posedge clk);
        #1;
        Pselx   = '0;
        Penable = 1'b0;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bad_phase = 1'b0;
        model_clear();
        @(negedge clk);
        chk("rst_prdata", Prdata, 32'h0);
        chk("rst_proto_err", 32'(proto_err), 32'h0);
        chk("rst_wr_count", 32'(wr_count), 32'h0);
        chk("rst_rd_count", 32'(rd_count), 32'h0);
        @(posedge clk);
        #1;
        xfer(1'b0, 32'h8000_000C, 32'h0);

        // Plain write/read round trip and the read-only ID word.
        xfer(1'b1, 32'h8000_0008, 32'h1234_5678);
        xfer(1'b0, 32'h8000_0008, 32'h0);
        xfer(1'b0, 32'h8000_0000, 32'h0);
        xfer(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        xfer(1'b0, 32'h8000_0000, 32'h0);

        // Random traffic with foreign selects toggling in the gaps.
        for (int k = 0; k < 80; k++) begin
            idle($urandom_range(0, 2));
            xfer($urandom_range(0, 1) == 1, $urandom, $urandom);
        end
        idle(1);

        // Back-to-back writes to 1..15, then an aliasing address.
        do_reset();
        for (int i = 1; i < 16; i++) begin
            xfer(1'b1, 32'h8000_0000 + 32'(i * 4), 32'hC0DE_0000 + 32'(i));
        end
        xfer(1'b1, 32'h8000_0044, 32'h5A5A_0001);
        xfer(1'b0, 32'h8000_0004, 32'h0);
        xfer(1'b0, 32'h8000_0044, 32'h0);
        xfer(1'b0, 32'h8000_0008, 32'h0);
        idle(2);

        // Penable high with select while idle.
        bad_phase = 1'b1;
        Pselx   = 3'b010;
        Penable = 1'b1;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_0014;
        Pwdata  = 32'h0BAD_0001;
        @(posedge clk);
        #1;
        Pselx     = '0;
        Penable   = 1'b0;
        bad_phase = 1'b0;
        m_err     = 1'b1;
        xfer(1'b0, 32'h8000_0014, 32'h0);

        // Address changed during the access phase of a write.
        do_reset();
        xfer(1'b1, 32'h8000_0014, 32'h5555_AAAA);
        bad_phase = 1'b1;
        Pselx   = 3'b010;
        Penable = 1'b0;
        Pwrite  = 1'b1;
        Paddr   = 32'h8000_0014;
        Pwdata  = 32'hBAD0_BAD0;
        @(posedge clk);
        #1;
        Penable = 1'b1;
        Paddr   = 32'h8000_0018;
        @(posedge clk);
        #1;
        Pselx     = '0;
        Penable   = 1'b0;
        bad_phase = 1'b0;
        m_err     = 1'b1;
        xfer(1'b0, 32'h8000_0014, 32'h0);
        xfer(1'b0, 32'h8000_0018, 32'h0);

        for (int k = 0; k < 20; k++) begin
            idle($urandom_range(0, 1));
            xfer($urandom_range(0, 1) == 1, $urandom, $urandom);
        end

        idle(3);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("final_wr_count", 32'(wr_count), 32'(m_wr));
        chk("final_rd_count", 32'(rd_count), 32'(m_rd));
        chk("final_proto_err", 32'(proto_err), 32'(m_err));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
